pipeline_hazard_ctrl: RTL and testbench
=======================================

// Module: pipeline_hazard_ctrl
// PURPOSE
//  Central stall/flush sequencer for the 5-stage pipeline. Detects load-use hazards that the ID
//  forwarding network cannot resolve, holds the front end for multi-cycle EX ops (MULT/DIV) and
//  applies pipeline flushes. Drives the per-stage hold vector and the bubble-insert strobes
//  consumed by the PC, IF/ID, ID/EX and EX/MEM registers.
// PARAMETERS
//  CNT_W   6   width of the multi-cycle countdown counter
//  MC_MAX  34  maximum accepted multi-cycle latency; larger requests are clamped to MC_MAX
//  PERF_W  32  width of the stall-cycle performance counter
// PORTS
//  clk           in   1      clock, rising edge
//  rst           in   1      reset rst, synchronous, active-high
//  id_re1        in   1      ID reads source 1 from the regfile
//  id_re2        in   1      ID reads source 2 from the regfile
//  id_raddr1     in   5      ID source-1 register address
//  id_raddr2     in   5      ID source-2 register address
//  ex_mem_re     in   1      instruction in EX is a load
//  ex_we         in   1      instruction in EX writes the regfile
//  ex_waddr      in   5      EX destination register
//  ex_mc_start   in   1      EX begins a multi-cycle op this cycle
//  ex_mc_cycles  in   CNT_W  total EX occupancy of that op, in cycles
//  flush_req     in   1      flush request (exception or redirect), single-cycle pulse
//  stall         out  6      hold vector: [0]PC [1]IF/ID [2]ID/EX [3]EX/MEM [4]MEM/WB [5]rsvd
//  id_ex_bubble  out  1      load NOP into ID/EX this cycle
//  ex_mem_bubble out  1      load NOP into EX/MEM this cycle
//  flush         out  1      clear IF/ID, ID/EX, EX/MEM this cycle
//  mc_done       out  1      last cycle of a multi-cycle op; EX captures its result
//  mc_abort      out  1      a multi-cycle op was killed by flush
//  busy          out  1      state != RUN
//  stall_cycles  out  PERF_W saturating count of cycles with stall != 0
// BEHAVIOUR
//  - Reset: state=RUN, cnt=0, stall_cycles=0. All outputs 0 in the cycle rst is sampled high,
//    including when it arrives mid-MC_WAIT.
//  - stall, bubbles, flush, mc_done and mc_abort are Mealy outputs: a function of state and this
//    cycle's inputs. State, cnt and stall_cycles are registered.
//  - Load-use (RUN only): lu = ex_mem_re & ex_we & ex_waddr!=0 &
//    ((id_re1 & id_raddr1==ex_waddr) | (id_re2 & id_raddr2==ex_waddr)).
//    lu -> stall=6'b000011 and id_ex_bubble=1 for exactly one cycle. No state change; the
//    next cycle the load is in MEM and ID forwards from the MEM/WB path.
//  - Multi-cycle: N = (ex_mc_cycles==0) ? 1 : min(ex_mc_cycles, MC_MAX).
//    ex_mc_start in RUN -> stall=6'b000111 and ex_mem_bubble=1 on the start cycle.
//    N==1: mc_done=1 on the start cycle; stay in RUN.
//    N>1: cnt<=N-1, go to MC_WAIT.
//  - MC_WAIT: stall=6'b000111 and ex_mem_bubble=1 every cycle; cnt decrements each cycle.
//    When cnt==1: mc_done=1, next state RUN. Total stall = exactly N cycles including the start
//    cycle. ex_mc_start and lu are ignored in MC_WAIT.
//  - Flush (highest priority, any state): flush=1, stall=0, both bubbles=0, mc_done=0.
//    In MC_WAIT, or coincident with ex_mc_start: mc_abort=1, cnt<=0, next state RUN.
//  - Priority: flush > multi-cycle (start or wait) > load-use. ex_mc_start together with lu:
//    the mc stall is applied and lu is not reported.
//  - stall_cycles: +1 per cycle with stall!=0; holds at all-ones (no wrap-around).
//  - cnt arithmetic is unsigned CNT_W bits; MC_MAX must be < 2**CNT_W.
// STRUCTURE
//  - defines.v: STALL_PC/IF/ID/EX/MEM bit indices, HCTRL_RUN/HCTRL_MC_WAIT state codes,
//    STALL_LOADUSE (6'b000011), STALL_MC (6'b000111), RegAddrBus.
//  - One sub-module, load_use_detect: the combinational lu equation above. Lets the bench
//    drive lu checks in isolation. The FSM and counters stay in this module.
// TESTING
//  1. lw $2 in EX (ex_mem_re=1, ex_waddr=2), ID reads raddr1=2 with re1=1 -> one cycle
//     stall=000011 and id_ex_bubble=1, then stall=0. Same with ex_waddr=0 -> no stall.
//  2. ex_mc_start, ex_mc_cycles=34 -> stall=000111 for exactly 34 cycles; mc_done only on
//     the 34th; busy=1 for 33 cycles.
//  3. ex_mc_cycles=0 and ex_mc_cycles=1 -> one stall cycle with mc_done=1; ex_mc_cycles=50
//     -> clamped to 34 stall cycles.
//  4. flush_req in the 10th cycle of a 34-cycle op -> that cycle flush=1, stall=0, mc_abort=1;
//     next cycle RUN and busy=0.
//  5. ex_mc_start and lu in the same cycle -> mc stall only. flush_req and lu together ->
//     flush=1, no bubble.
//  6. rst asserted mid-MC_WAIT -> next cycle all outputs 0; stall_cycles preset to
//     all-ones minus 1 and then stalled twice -> saturates at all-ones.

Source files
------------

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// rtl/pipeline_hazard_ctrl_pkg.sv - shared constants for the pipeline stall/flush sequencer
package pipeline_hazard_ctrl_pkg;

  localparam int STALL_PC = 0;
  localparam int STALL_IF = 1;
  localparam int STALL_ID = 2;

  localparam logic [0:0] HCTRL_RUN     = 1'b0;
  localparam logic [0:0] HCTRL_MC_WAIT = 1'b1;

  localparam logic [5:0] STALL_NONE    = 6'b000000;
  localparam logic [5:0] STALL_LOADUSE = (6'(1) << STALL_PC) | (6'(1) << STALL_IF);
  localparam logic [5:0] STALL_MC      = STALL_LOADUSE | (6'(1) << STALL_ID);

  typedef logic [4:0] reg_addr_t;

endpackage

// File: rtl/pipeline_hazard_ctrl_load_use_detect.sv
// rtl/pipeline_hazard_ctrl_load_use_detect.sv - load-use hazard the ID forwarding cannot cover
module pipeline_hazard_ctrl_load_use_detect
  import pipeline_hazard_ctrl_pkg::*;
(
  input  logic      id_re1_i,
  input  logic      id_re2_i,
  input  reg_addr_t id_raddr1_i,
  input  reg_addr_t id_raddr2_i,
  input  logic      ex_mem_re_i,
  input  logic      ex_we_i,
  input  reg_addr_t ex_waddr_i,
  output logic      lu_o
);

  logic src1_hit;
  logic src2_hit;

  assign src1_hit = id_re1_i & (id_raddr1_i == ex_waddr_i);
  assign src2_hit = id_re2_i & (id_raddr2_i == ex_waddr_i);

  // r0 is hardwired zero, so a load targeting it never creates a dependency
  assign lu_o = ex_mem_re_i & ex_we_i & (ex_waddr_i != '0) & (src1_hit | src2_hit);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - stall/flush sequencer: load-use, multi-cycle EX hold, flush
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int CNT_W  = 6,
  parameter int MC_MAX = 34,
  parameter int PERF_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_re1_i,
  input  logic              id_re2_i,
  input  logic [4:0]        id_raddr1_i,
  input  logic [4:0]        id_raddr2_i,
  input  logic              ex_mem_re_i,
  input  logic              ex_we_i,
  input  logic [4:0]        ex_waddr_i,
  input  logic              ex_mc_start_i,
  input  logic [CNT_W-1:0]  ex_mc_cycles_i,
  input  logic              flush_req_i,
  output logic [5:0]        stall_o,
  output logic              id_ex_bubble_o,
  output logic              ex_mem_bubble_o,
  output logic              flush_o,
  output logic              mc_done_o,
  output logic              mc_abort_o,
  output logic              busy_o,
  output logic [PERF_W-1:0] stall_cycles_o
);

  localparam logic [CNT_W-1:0] MC_MAX_C = CNT_W'(MC_MAX);
  localparam logic [CNT_W-1:0] ONE_C    = CNT_W'(1);

  logic [0:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [PERF_W-1:0] perf_q, perf_d;
  logic [CNT_W-1:0]  mc_len;
  logic              lu;

  pipeline_hazard_ctrl_load_use_detect u_lu (
    .id_re1_i    (id_re1_i),
    .id_re2_i    (id_re2_i),
    .id_raddr1_i (id_raddr1_i),
    .id_raddr2_i (id_raddr2_i),
    .ex_mem_re_i (ex_mem_re_i),
    .ex_we_i     (ex_we_i),
    .ex_waddr_i  (ex_waddr_i),
    .lu_o        (lu)
  );

  // A zero-length request still occupies EX for one cycle
  assign mc_len = (ex_mc_cycles_i == '0)     ? ONE_C    :
                  (ex_mc_cycles_i > MC_MAX_C) ? MC_MAX_C : ex_mc_cycles_i;

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    stall_o         = STALL_NONE;
    id_ex_bubble_o  = 1'b0;
    ex_mem_bubble_o = 1'b0;
    flush_o         = 1'b0;
    mc_done_o       = 1'b0;
    mc_abort_o      = 1'b0;
    if (rst) begin
      state_d = HCTRL_RUN;
      cnt_d   = '0;
    end else if (flush_req_i) begin
      flush_o    = 1'b1;
      mc_abort_o = (state_q == HCTRL_MC_WAIT) | ex_mc_start_i;
      state_d    = HCTRL_RUN;
      cnt_d      = '0;
    end else if (state_q == HCTRL_MC_WAIT) begin
      stall_o         = STALL_MC;
      ex_mem_bubble_o = 1'b1;
      cnt_d           = cnt_q - ONE_C;
      if (cnt_q == ONE_C) begin
        mc_done_o = 1'b1;
        state_d   = HCTRL_RUN;
      end
    end else if (ex_mc_start_i) begin
      stall_o         = STALL_MC;
      ex_mem_bubble_o = 1'b1;
      if (mc_len == ONE_C) begin
        mc_done_o = 1'b1;
      end else begin
        cnt_d   = mc_len - ONE_C;
        state_d = HCTRL_MC_WAIT;
      end
    end else if (lu) begin
      stall_o        = STALL_LOADUSE;
      id_ex_bubble_o = 1'b1;
    end
  end

  always_comb begin
    perf_d = perf_q;
    if ((stall_o != STALL_NONE) && (perf_q != '1)) begin
      perf_d = perf_q + PERF_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= HCTRL_RUN;
      cnt_q   <= '0;
      perf_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      perf_q  <= perf_d;
    end
  end

  // Registered observables are masked too so every output reads 0 while rst is sampled
  assign busy_o         = ~rst & (state_q != HCTRL_RUN);
  assign stall_cycles_o = rst ? '0 : perf_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - directed self-checking bench for pipeline_hazard_ctrl
module tb_pipeline_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_re1, id_re2, ex_mem_re, ex_we, ex_mc_start, flush_req;
  logic [4:0] id_raddr1, id_raddr2, ex_waddr;
  logic [5:0] ex_mc_cycles;
  logic [5:0] stall;
  logic       id_ex_bubble, ex_mem_bubble, flush, mc_done, mc_abort, busy;
  logic [5:0] stall_cycles;

  int n_cmp = 0;
  int n_bad = 0;
  int n_stall, done_at, n_busy;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.CNT_W(6), .MC_MAX(34), .PERF_W(6)) dut (
    .clk             (clk),
    .rst             (rst),
    .id_re1_i        (id_re1),
    .id_re2_i        (id_re2),
    .id_raddr1_i     (id_raddr1),
    .id_raddr2_i     (id_raddr2),
    .ex_mem_re_i     (ex_mem_re),
    .ex_we_i         (ex_we),
    .ex_waddr_i      (ex_waddr),
    .ex_mc_start_i   (ex_mc_start),
    .ex_mc_cycles_i  (ex_mc_cycles),
    .flush_req_i     (flush_req),
    .stall_o         (stall),
    .id_ex_bubble_o  (id_ex_bubble),
    .ex_mem_bubble_o (ex_mem_bubble),
    .flush_o         (flush),
    .mc_done_o       (mc_done),
    .mc_abort_o      (mc_abort),
    .busy_o          (busy),
    .stall_cycles_o  (stall_cycles)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic idle();
    id_re1 = 0; id_re2 = 0; id_raddr1 = 0; id_raddr2 = 0;
    ex_mem_re = 0; ex_we = 0; ex_waddr = 0;
    ex_mc_start = 0; ex_mc_cycles = 0; flush_req = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_use(input logic [4:0] dst);
    ex_mem_re = 1; ex_we = 1; ex_waddr = dst; id_re1 = 1; id_raddr1 = dst;
  endtask

  // Issues one multi-cycle op and watches it until stall drops (bounded)
  task automatic run_mc(input logic [5:0] cyc, output int ns, output int da, output int nb);
    idle();
    ex_mc_start = 1; ex_mc_cycles = cyc;
    ns = 0; da = -1; nb = 0;
    for (int i = 1; i <= 70; i++) begin
      @(negedge clk);
      if (stall == 6'b0) begin
        tick();
        break;
      end
      if (stall == 6'b000111) ns++;
      if (mc_done) da = (da < 0) ? i : -2;
      if (busy) nb++;
      tick();
      idle();
    end
  endtask

  initial begin
    idle();
    rst = 1;
    @(negedge clk);
    check("rst_stall", 32'(stall), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_perf", 32'(stall_cycles), 0);
    tick();
    rst = 0;

    load_use(5'd2);
    @(negedge clk);
    check("lu_stall", 32'(stall), 32'b000011);
    check("lu_idex_bubble", 32'(id_ex_bubble), 1);
    check("lu_exmem_bubble", 32'(ex_mem_bubble), 0);
    tick(); idle();
    @(negedge clk);
    check("lu_after_stall", 32'(stall), 0);
    check("lu_perf", 32'(stall_cycles), 1);
    tick();
    load_use(5'd0);
    @(negedge clk);
    check("lu_r0_stall", 32'(stall), 0);
    check("lu_r0_bubble", 32'(id_ex_bubble), 0);
    tick(); idle();
    ex_mem_re = 1; ex_we = 1; ex_waddr = 7; id_re2 = 1; id_raddr2 = 7; id_raddr1 = 7;
    @(negedge clk);
    check("lu_src2_stall", 32'(stall), 32'b000011);
    tick();
    ex_mem_re = 0;
    @(negedge clk);
    check("not_load_stall", 32'(stall), 0);
    tick();

    run_mc(6'd34, n_stall, done_at, n_busy);
    check("mc34_stall_cycles", 32'(n_stall), 34);
    check("mc34_done_at", 32'(done_at), 34);
    check("mc34_busy_cycles", 32'(n_busy), 33);
    @(negedge clk);
    check("mc34_busy_after", 32'(busy), 0);
    check("mc34_perf", 32'(stall_cycles), 36);
    tick();

    run_mc(6'd0, n_stall, done_at, n_busy);
    check("mc0_stall_cycles", 32'(n_stall), 1);
    check("mc0_done_at", 32'(done_at), 1);
    check("mc0_busy_cycles", 32'(n_busy), 0);
    run_mc(6'd1, n_stall, done_at, n_busy);
    check("mc1_stall_cycles", 32'(n_stall), 1);
    check("mc1_done_at", 32'(done_at), 1);
    run_mc(6'd50, n_stall, done_at, n_busy);
    check("mc50_clamp_stall", 32'(n_stall), 34);
    check("mc50_done_at", 32'(done_at), 34);
    @(negedge clk);
    check("perf_saturated", 32'(stall_cycles), 63);
    tick();

    idle(); ex_mc_start = 1; ex_mc_cycles = 34;
    tick(); idle();
    repeat (3) tick();
    load_use(5'd4); ex_mc_start = 1; ex_mc_cycles = 2;
    @(negedge clk);
    check("wait_ignores_lu_stall", 32'(stall), 32'b000111);
    check("wait_ignores_lu_bubble", 32'(id_ex_bubble), 0);
    check("wait_ignores_start_done", 32'(mc_done), 0);
    tick(); idle();
    repeat (4) tick();
    flush_req = 1;
    @(negedge clk);
    check("abort_flush", 32'(flush), 1);
    check("abort_stall", 32'(stall), 0);
    check("abort_mc_abort", 32'(mc_abort), 1);
    check("abort_mc_done", 32'(mc_done), 0);
    check("abort_exmem_bubble", 32'(ex_mem_bubble), 0);
    tick(); idle();
    @(negedge clk);
    check("abort_busy_after", 32'(busy), 0);
    check("abort_stall_after", 32'(stall), 0);
    tick();

    load_use(5'd3); ex_mc_start = 1; ex_mc_cycles = 1;
    @(negedge clk);
    check("mc_lu_stall", 32'(stall), 32'b000111);
    check("mc_lu_idex_bubble", 32'(id_ex_bubble), 0);
    check("mc_lu_exmem_bubble", 32'(ex_mem_bubble), 1);
    check("mc_lu_done", 32'(mc_done), 1);
    tick(); idle();
    load_use(5'd3); flush_req = 1;
    @(negedge clk);
    check("flush_lu_flush", 32'(flush), 1);
    check("flush_lu_stall", 32'(stall), 0);
    check("flush_lu_bubble", 32'(id_ex_bubble), 0);
    check("flush_lu_abort", 32'(mc_abort), 0);
    tick(); idle();
    flush_req = 1; ex_mc_start = 1; ex_mc_cycles = 20;
    @(negedge clk);
    check("flush_start_abort", 32'(mc_abort), 1);
    check("flush_start_stall", 32'(stall), 0);
    tick(); idle();
    @(negedge clk);
    check("flush_start_busy", 32'(busy), 0);
    tick();

    ex_mc_start = 1; ex_mc_cycles = 34;
    tick(); idle();
    repeat (4) tick();
    rst = 1;
    @(negedge clk);
    check("rst_mid_stall", 32'(stall), 0);
    check("rst_mid_busy", 32'(busy), 0);
    check("rst_mid_done", 32'(mc_done), 0);
    check("rst_mid_exmem_bubble", 32'(ex_mem_bubble), 0);
    check("rst_mid_perf", 32'(stall_cycles), 0);
    tick();
    rst = 0;
    @(negedge clk);
    check("post_rst_busy", 32'(busy), 0);
    check("post_rst_stall", 32'(stall), 0);
    tick();

    run_mc(6'd34, n_stall, done_at, n_busy);
    check("refill_mc34", 32'(n_stall), 34);
    run_mc(6'd28, n_stall, done_at, n_busy);
    check("refill_mc28", 32'(n_stall), 28);
    @(negedge clk);
    check("perf_max_minus_1", 32'(stall_cycles), 62);
    tick();
    load_use(5'd9);
    tick(); idle();
    @(negedge clk);
    check("perf_reach_max", 32'(stall_cycles), 63);
    tick();
    load_use(5'd9);
    tick(); idle();
    @(negedge clk);
    check("perf_hold_max", 32'(stall_cycles), 63);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
